// File: rtl/csc_pkg.sv
// Shared constants for the YUV->RGB pair converter: fixed-point coefficients,
// input offsets and the controller state encoding.
package csc_pkg;

    localparam logic signed [31:0] COEF_Y   = 32'sd76284;
    localparam logic signed [31:0] COEF_RV  = 32'sd104595;
    localparam logic signed [31:0] COEF_GU  = -32'sd25624;
    localparam logic signed [31:0] COEF_GV  = -32'sd53281;
    localparam logic signed [31:0] COEF_BU  = 32'sd132251;

    localparam logic signed [31:0] OFFSET_Y = 32'sd16;
    localparam logic signed [31:0] OFFSET_C = 32'sd128;

    localparam logic [3:0] LAST_STEP = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_WRITE = 2'd2
    } csc_state_e;

endpackage

// File: rtl/csc_clip8.sv
// Saturates a signed 32-bit value into the unsigned 8-bit range [0,255].
module csc_clip8 (
    input  logic signed [31:0] val_i,
    output logic [7:0]         clip_o
);

    always_comb begin
        clip_o = val_i[7:0];
        if (val_i[31]) begin
            clip_o = 8'd0;
        end else if (val_i > 32'sd255) begin
            clip_o = 8'hFF;
        end
    end

endmodule

// File: rtl/csc_rgb_pipe.sv
// Converts one YUV pixel pair to three packed RGB words using a single shared
// multiplier stepped through ten products, then hands the words out in order.
module csc_rgb_pipe (
    input  logic        CLOCK_50_I,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] Y_pair,
    input  logic [31:0] even_U,
    input  logic [31:0] even_V,
    input  logic [31:0] odd_U,
    input  logic [31:0] odd_V,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_word,
    output logic [1:0]  out_index
);
    import csc_pkg::*;

    csc_state_e         state_q, state_d;
    logic [3:0]         step_q;
    logic [1:0]         idx_q;
    logic [7:0]         y_q [2];
    logic [7:0]         u_q [2];
    logic [7:0]         v_q [2];
    logic signed [31:0] prod_q;
    logic               prod_vld_q;
    logic [2:0]         prod_kind_q;
    logic               prod_pix_q;
    logic signed [31:0] acc_r_q [2];
    logic signed [31:0] acc_g_q [2];
    logic signed [31:0] acc_b_q [2];

    logic               accept;
    logic               word_done;
    logic               pix_w;
    logic [2:0]         kind_w;
    logic signed [31:0] y_s, u_s, v_s;
    logic signed [31:0] mul_a, mul_b, prod_w;
    logic [31:0]        chroma_raw [4];
    logic [7:0]         chroma_clip [4];
    logic [7:0]         ch_r [2];
    logic [7:0]         ch_g [2];
    logic [7:0]         ch_b [2];

    assign in_ready  = (state_q == ST_IDLE);
    // The last product is still in the pipeline register on the first WRITE cycle.
    assign out_valid = (state_q == ST_WRITE) && !prod_vld_q;
    assign out_index = idx_q;
    assign accept    = in_valid && in_ready && !flush;
    assign word_done = out_valid && out_ready;

    assign chroma_raw[0] = even_U;
    assign chroma_raw[1] = even_V;
    assign chroma_raw[2] = odd_U;
    assign chroma_raw[3] = odd_V;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chroma
            csc_clip8 u_clip (.val_i($signed(chroma_raw[gi])), .clip_o(chroma_clip[gi]));
        end
        for (gi = 0; gi < 2; gi++) begin : g_chan
            csc_clip8 u_clip_r (.val_i(acc_r_q[gi] >>> 16), .clip_o(ch_r[gi]));
            csc_clip8 u_clip_g (.val_i(acc_g_q[gi] >>> 16), .clip_o(ch_g[gi]));
            csc_clip8 u_clip_b (.val_i(acc_b_q[gi] >>> 16), .clip_o(ch_b[gi]));
        end
    endgenerate

    // Steps 0..4 belong to the even pixel, 5..9 to the odd pixel.
    always_comb begin
        pix_w  = 1'b0;
        kind_w = step_q[2:0];
        if (step_q >= 4'd5) begin
            pix_w  = 1'b1;
            kind_w = 3'(step_q - 4'd5);
        end
        y_s   = $signed({24'd0, y_q[pix_w]}) - OFFSET_Y;
        u_s   = $signed({24'd0, u_q[pix_w]}) - OFFSET_C;
        v_s   = $signed({24'd0, v_q[pix_w]}) - OFFSET_C;
        mul_a = COEF_BU;
        mul_b = u_s;
        case (kind_w)
            3'd0:    begin mul_a = COEF_Y;  mul_b = y_s; end
            3'd1:    begin mul_a = COEF_RV; mul_b = v_s; end
            3'd2:    begin mul_a = COEF_GU; mul_b = u_s; end
            3'd3:    begin mul_a = COEF_GV; mul_b = v_s; end
            default: ;
        endcase
        prod_w = mul_a * mul_b;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_MUL;
            ST_MUL:   if (step_q == LAST_STEP) state_d = ST_WRITE;
            ST_WRITE: if (word_done && idx_q == 2'd2) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            step_q      <= '0;
            idx_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            prod_kind_q <= '0;
            prod_pix_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                y_q[i]     <= '0;
                u_q[i]     <= '0;
                v_q[i]     <= '0;
                acc_r_q[i] <= '0;
                acc_g_q[i] <= '0;
                acc_b_q[i] <= '0;
            end
        end else if (flush) begin
            step_q     <= '0;
            idx_q      <= '0;
            prod_vld_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                acc_r_q[i] <= '0;
                acc_g_q[i] <= '0;
                acc_b_q[i] <= '0;
            end
        end else begin
            prod_vld_q <= 1'b0;
            if (accept) begin
                y_q[0] <= Y_pair[15:8];
                y_q[1] <= Y_pair[7:0];
                u_q[0] <= chroma_clip[0];
                v_q[0] <= chroma_clip[1];
                u_q[1] <= chroma_clip[2];
                v_q[1] <= chroma_clip[3];
                step_q <= '0;
                idx_q  <= '0;
                for (int i = 0; i < 2; i++) begin
                    acc_r_q[i] <= '0;
                    acc_g_q[i] <= '0;
                    acc_b_q[i] <= '0;
                end
            end
            if (state_q == ST_MUL) begin
                prod_q      <= prod_w;
                prod_vld_q  <= 1'b1;
                prod_kind_q <= kind_w;
                prod_pix_q  <= pix_w;
                step_q      <= (step_q == LAST_STEP) ? 4'd0 : step_q + 4'd1;
            end
            if (prod_vld_q) begin
                case (prod_kind_q)
                    3'd0: begin
                        acc_r_q[prod_pix_q] <= acc_r_q[prod_pix_q] + prod_q;
                        acc_g_q[prod_pix_q] <= acc_g_q[prod_pix_q] + prod_q;
                        acc_b_q[prod_pix_q] <= acc_b_q[prod_pix_q] + prod_q;
                    end
                    3'd1:       acc_r_q[prod_pix_q] <= acc_r_q[prod_pix_q] + prod_q;
                    3'd2, 3'd3: acc_g_q[prod_pix_q] <= acc_g_q[prod_pix_q] + prod_q;
                    default:    acc_b_q[prod_pix_q] <= acc_b_q[prod_pix_q] + prod_q;
                endcase
            end
            if (word_done) begin
                idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            end
        end
    end

    always_comb begin
        out_word = {ch_g[1], ch_b[1]};
        case (idx_q)
            2'd0:    out_word = {ch_r[0], ch_g[0]};
            2'd1:    out_word = {ch_b[0], ch_r[1]};
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csc_rgb_pipe.sv
// Scoreboard bench for csc_rgb_pipe: directed pairs with hand-computed words,
// plus latency, back-pressure, reset and flush scenarios.
module tb_csc_rgb_pipe;

    logic        CLOCK_50_I = 1'b0;
    logic        resetn     = 1'b0;
    logic        flush      = 1'b0;
    logic        in_valid   = 1'b0;
    logic        in_ready;
    logic [15:0] Y_pair     = '0;
    logic [31:0] even_U     = '0;
    logic [31:0] even_V     = '0;
    logic [31:0] odd_U      = '0;
    logic [31:0] odd_V      = '0;
    logic        out_valid;
    logic        out_ready  = 1'b1;
    logic [15:0] out_word;
    logic [1:0]  out_index;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q [$];
    int word_no = 0;

    csc_rgb_pipe dut (
        .CLOCK_50_I (CLOCK_50_I),
        .resetn     (resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Y_pair     (Y_pair),
        .even_U     (even_U),
        .even_V     (even_V),
        .odd_U      (odd_U),
        .odd_V      (odd_V),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_index  (out_index)
    );

    always #5 CLOCK_50_I = ~CLOCK_50_I;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops the expected word whenever a word handshake is about to happen.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge CLOCK_50_I);
            if (resetn && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {14'd0, out_index, out_word}, 32'h0003_FFFF ^ {14'd0, out_index, out_word});
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("word%0d", word_no), 32'(out_word), 32'(e[15:0]));
                    check($sformatf("index%0d", word_no), 32'(out_index), 32'(e[17:16]));
                    $display("word %0d: index %0d data 0x%04h (expected 0x%04h)", word_no, out_index, out_word, e[15:0]);
                    word_no++;
                end
            end
        end
    end

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        @(negedge CLOCK_50_I);
        while (!in_ready && n < 200) begin
            @(negedge CLOCK_50_I);
            n++;
        end
        if (!in_ready) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    task automatic drive(input logic [15:0] y, input logic [31:0] eu, ev, ou, ov);
        Y_pair = y;
        even_U = eu;
        even_V = ev;
        odd_U  = ou;
        odd_V  = ov;
    endtask

    task automatic scramble();
        drive(16'(~Y_pair), $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic send_pair(input string tag, input logic [15:0] y, input logic [31:0] eu, ev, ou, ov,
                             input logic [15:0] w0, w1, w2);
        int n;
        wait_ready(tag);
        drive(y, eu, ev, ou, ov);
        in_valid = 1'b1;
        exp_q.push_back({2'd0, w0});
        exp_q.push_back({2'd1, w1});
        exp_q.push_back({2'd2, w2});
        @(posedge CLOCK_50_I);
        #1;
        in_valid = 1'b0;
        scramble();
        $display("pair %s: Y=0x%04h accepted, expecting 0x%04h 0x%04h 0x%04h", tag, y, w0, w1, w2);
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge CLOCK_50_I);
            #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd11);
    endtask

    task automatic watch_quiet(input string name, input int cycles);
        int cnt;
        cnt = 0;
        repeat (cycles) begin
            @(posedge CLOCK_50_I);
            #1;
            if (out_valid) cnt++;
        end
        check(name, 32'(cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_word", 32'(out_word), 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        #20;
        resetn = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        send_pair("black", 16'h1010, 32'd128, 32'd128, 32'd128, 32'd128, 16'h0000, 16'h0000, 16'h0000);
        send_pair("white", 16'hEBFF, 32'd128, 32'd128, 32'd128, 32'd128, 16'hFEFE, 16'hFEFF, 16'hFFFF);
        send_pair("red",   16'h8000, 32'd128, 32'd255, 32'd128, 32'd128, 16'hFF1B, 16'h8200, 16'h0000);
        send_pair("oddclip", 16'h1080, 32'd128, 32'd128, 32'hFFFF_FFFB, 32'd300, 16'h0000, 16'h00FF, 16'h4D00);
        send_pair("mixed", 16'h643C, 32'd200, 32'd50, 32'd90, 32'd170, 16'h0085, 16'hF376, 16'h1F00);

        // Back-pressure on word 1 while a new pair is offered.
        send_pair("stall", 16'h8000, 32'd128, 32'd255, 32'd128, 32'd128, 16'hFF1B, 16'h8200, 16'h0000);
        @(posedge CLOCK_50_I);
        #1;
        out_ready = 1'b0;
        drive(16'h1010, 32'd128, 32'd128, 32'd128, 32'd128);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall_word_c%0d", c), 32'(out_word), 32'h8200);
            check($sformatf("stall_index_c%0d", c), 32'(out_index), 32'd1);
            check($sformatf("stall_valid_c%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("stall_in_ready_c%0d", c), 32'(in_ready), 32'd0);
            @(posedge CLOCK_50_I);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset pulse while the multiplier is on step 4.
        wait_ready("rstmul");
        drive(16'hEBFF, 32'd128, 32'd128, 32'd128, 32'd128);
        in_valid = 1'b1;
        @(posedge CLOCK_50_I);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge CLOCK_50_I);
        #2;
        resetn = 1'b0;
        #1;
        check("rstmul_out_valid", 32'(out_valid), 32'd0);
        check("rstmul_out_word", 32'(out_word), 32'd0);
        check("rstmul_out_index", 32'(out_index), 32'd0);
        @(negedge CLOCK_50_I);
        resetn = 1'b1;
        #1;
        check("rstmul_in_ready", 32'(in_ready), 32'd1);
        $display("reset pulse during multiply applied");
        watch_quiet("rstmul_quiet", 15);

        // flush together with in_valid in IDLE: nothing accepted.
        @(negedge CLOCK_50_I);
        drive(16'h8000, 32'd128, 32'd255, 32'd128, 32'd128);
        flush    = 1'b1;
        in_valid = 1'b1;
        @(posedge CLOCK_50_I);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flushidle_in_ready", 32'(in_ready), 32'd1);
        $display("flush with in_valid applied");
        watch_quiet("flushidle_quiet", 15);

        // flush in the middle of a multiply discards the pair.
        wait_ready("flushmul");
        drive(16'hEBFF, 32'd128, 32'd128, 32'd128, 32'd128);
        in_valid = 1'b1;
        @(posedge CLOCK_50_I);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge CLOCK_50_I);
        #1;
        flush = 1'b1;
        @(posedge CLOCK_50_I);
        #1;
        flush = 1'b0;
        check("flushmul_in_ready", 32'(in_ready), 32'd1);
        check("flushmul_out_valid", 32'(out_valid), 32'd0);
        $display("flush during multiply applied");
        watch_quiet("flushmul_quiet", 15);

        send_pair("recover", 16'h643C, 32'd200, 32'd50, 32'd90, 32'd170, 16'h0085, 16'hF376, 16'h1F00);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge CLOCK_50_I);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge CLOCK_50_I);
        #1;
        check("final_in_ready", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csc_rgb_pipe.md
CSC_RGB_PIPE -- requirements
Module: csc_rgb_pipe

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: CLOCK_50_I  input  1  clock; all state updates on the rising edge.
REQ-003 Port: resetn  input  1  asynchronous active-low reset.
REQ-004 Port: flush  input  1  synchronous abort to IDLE.
REQ-005 Port: in_valid  input  1  a pixel pair is presented.
REQ-006 Port: in_ready  output  1  block accepts a pair this cycle.
REQ-007 Port: Y_pair  input  16  [15:8] is even Y, [7:0] is odd Y, unsigned.
REQ-008 Port: even_U, even_V  input  32 each  even chroma, zero-extended 8-bit.
REQ-009 Port: odd_U, odd_V  input  32 each  upsampled odd chroma, signed two's complement.
REQ-010 Port: out_valid  output  1  out_word is valid.
REQ-011 Port: out_ready  input  1  downstream SRAM writer accepts out_word.
REQ-012 Port: out_word  output  16  packed RGB word.
REQ-013 Port: out_index  output  2  word number 0..2 within the pair.

Function
REQ-014 SHALL accept a pair on an edge where in_valid and in_ready are both 1, and capture all inputs on that edge.
REQ-015 SHALL drive in_ready=1 only in state IDLE.
REQ-016 SHALL clip odd_U and odd_V to [0,255] at capture: negative gives 0, above 255 gives 255.
REQ-017 FSM states: IDLE -> MUL on acceptance; MUL -> WRITE after 10 product cycles; WRITE -> IDLE after the handshake of word 2.
REQ-018 SHALL use one shared signed 32x32 multiplier with a 4-bit step counter 0..9.
REQ-019 MUL SHALL issue 5 products per pixel in a fixed order, even pixel first:
  - Y term: 76284*(Y-16)
  - R term: 104595*(V-128)
  - G terms: -25624*(U-128) and -53281*(V-128)
  - B term: 132251*(U-128)
REQ-020 Accumulators SHALL be signed 32-bit; there SHALL be one R, G and B accumulator per pixel.
REQ-021 Each channel result SHALL be the accumulator arithmetically shifted right by 16 (floor), then clipped to [0,255].
REQ-022 Word packing: word0={R0,G0}, word1={B0,R1}, word2={G1,B1}; the first named channel is in bits [15:8].
REQ-023 out_valid SHALL go high exactly 11 cycles after the acceptance edge.
REQ-024 out_word and out_index SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 SHALL advance to the next word on an edge where out_valid and out_ready are both 1; words are emitted in order 0,1,2.
REQ-026 After the word-2 handshake, SHALL drive out_valid=0 and in_ready=1 in the next cycle.
REQ-027 flush SHALL return the block to IDLE on the next edge from any state, discarding the partial pair; out_valid=0 from then on.
REQ-028 If flush and in_valid are both high, flush SHALL win and the pair SHALL NOT be accepted.

Reset
REQ-029 resetn low SHALL immediately force the following, aborting any pair in progress:
  - state IDLE, counters 0, accumulators 0
  - out_valid=0, out_word=0, out_index=0
  - in_ready=1 once resetn is high

Structure
REQ-030 A shared package csc_pkg SHALL hold the five coefficients, the offsets 16 and 128, and the FSM state enum.
REQ-031 A sub-module csc_clip8 SHALL perform the 32-bit signed to 8-bit unsigned saturation; it is instantiated for chroma capture and for channel output.

Verification
REQ-032 Y_pair=0x1010, U=V=128 (even and odd) -> words 0x0000, 0x0000, 0x0000.
REQ-033 Y_pair=0xEBFF, U=V=128 -> words 0xFEFE, 0xFEFF, 0xFFFF; pixel 0 is 254 in every channel, pixel 1 clips to 255.
REQ-034 Y_pair=0x8000, even V=255, even U=128, odd U=V=128 -> pixel 0 RGB=(255,27,130), pixel 1 RGB=(0,0,0); words 0xFF1B, 0x8200, 0x0000.
REQ-035 odd_U=-5, odd_V=300, odd Y=128 -> odd chroma used as U=0, V=255, and results match the clipped-input model.
REQ-036 Hold out_ready=0 for 5 cycles at word1 -> out_word and out_index stay stable, and no new pair is accepted.
REQ-037 Run the reset and flush checks:
  - resetn pulse during MUL step 4 -> all outputs reach their reset values at once.
  - flush and in_valid together -> nothing is accepted and no words are produced.
